// File: rtl/nn_seq_pkg.sv
// Shared types and constants for the layer sequencer and its delay line.
package nn_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_ISSUE = 3'd2,
    ST_DRAIN = 3'd3,
    ST_WRITE = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  localparam int RD_LAT_MAX = 3;
  localparam int PERF_W     = 16;

endpackage

// File: rtl/nn_seq_delay_line.sv
// LAT-stage shift register carrying {en,last} from the read strobe to the MAC strobe.
module nn_seq_delay_line
  import nn_seq_pkg::*;
#(
  parameter int LAT = 1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_flush,
  input  logic i_en,
  input  logic i_last,
  output logic o_en,
  output logic o_last
);

  // Out-of-range latencies are pinned to the supported 1..RD_LAT_MAX window.
  localparam int LAT_EFF = (LAT > RD_LAT_MAX) ? RD_LAT_MAX : ((LAT < 1) ? 1 : LAT);

  logic [LAT_EFF-1:0] r_en;
  logic [LAT_EFF-1:0] r_last;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_en   <= '0;
      r_last <= '0;
    end else if (i_flush) begin
      r_en   <= '0;
      r_last <= '0;
    end else begin
      r_en[0]   <= i_en;
      r_last[0] <= i_en & i_last;
      for (int i = 1; i < LAT_EFF; i++) begin
        r_en[i]   <= r_en[i-1];
        r_last[i] <= r_last[i-1];
      end
    end
  end

  assign o_en   = r_en[LAT_EFF-1];
  assign o_last = r_last[LAT_EFF-1];

endmodule

// File: rtl/nn_layer_sequencer.sv
// Layer evaluation sequencer: clear, issue reads, drain read latency, write, ack.
// Optional perf counters are built when LAYER_SEQ_PERF_EN is defined.
module nn_layer_sequencer
  import nn_seq_pkg::*;
#(
  parameter int AW     = 4,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req,
  input  logic          abort,
  input  logic [AW:0]   n_inputs,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  output logic          mac_clr,
  output logic          mac_en,
  output logic          mac_last,
  output logic          out_wr,
  output logic          ack,
  output logic          busy,
  output state_t        o_dbg_state
`ifdef LAYER_SEQ_PERF_EN
  ,
  output logic [PERF_W-1:0] perf_cycles,
  output logic [PERF_W-1:0] perf_jobs
`endif
);

  localparam logic [AW:0] MAX_N = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] ONE   = {{AW{1'b0}}, 1'b1};

  state_t      r_state;
  state_t      w_state_nxt;
  logic [AW:0] r_cnt;
  logic [AW:0] r_idx;
  logic [AW:0] w_n_clamped;
  logic        w_start;
  logic        w_flush;
  logic        w_issue_last;
  logic        w_mac_en;
  logic        w_mac_last;

  assign w_n_clamped  = (n_inputs > MAX_N) ? MAX_N : n_inputs;
  assign w_issue_last = (r_state == ST_ISSUE) && (r_idx == (r_cnt - ONE));
  assign w_flush      = abort && (r_state != ST_IDLE);

  // Holding req through DONE chains straight into the next job's CLEAR.
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (req) begin
          w_state_nxt = ST_CLEAR;
          w_start     = 1'b1;
        end
      end
      ST_CLEAR: w_state_nxt = (r_cnt == '0) ? ST_WRITE : ST_ISSUE;
      ST_ISSUE: if (w_issue_last) w_state_nxt = ST_DRAIN;
      ST_DRAIN: if (w_mac_last) w_state_nxt = ST_WRITE;
      ST_WRITE: w_state_nxt = ST_DONE;
      ST_DONE: begin
        if (req) begin
          w_state_nxt = ST_CLEAR;
          w_start     = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (w_flush) begin
      w_state_nxt = ST_IDLE;
      w_start     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_start) begin
        r_cnt <= w_n_clamped;
        r_idx <= '0;
      end else if (r_state == ST_ISSUE) begin
        r_idx <= r_idx + ONE;
      end
    end
  end

  nn_seq_delay_line #(
    .LAT (RD_LAT)
  ) u_delay_line (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_flush (w_flush),
    .i_en    (rd_en),
    .i_last  (w_issue_last),
    .o_en    (w_mac_en),
    .o_last  (w_mac_last)
  );

  assign rd_en       = (r_state == ST_ISSUE);
  assign rd_addr     = rd_en ? r_idx[AW-1:0] : '0;
  assign mac_clr     = (r_state == ST_CLEAR);
  assign mac_en      = w_mac_en;
  assign mac_last    = w_mac_last;
  assign out_wr      = (r_state == ST_WRITE);
  assign ack         = (r_state == ST_DONE);
  assign busy        = (r_state != ST_IDLE);
  assign o_dbg_state = r_state;

`ifdef LAYER_SEQ_PERF_EN
  logic [PERF_W-1:0] r_run;
  logic [PERF_W-1:0] r_perf_cycles;
  logic [PERF_W-1:0] r_perf_jobs;

  // r_run includes the current cycle, so at DONE it is the whole job length.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_run         <= '0;
      r_perf_cycles <= '0;
      r_perf_jobs   <= '0;
    end else begin
      if (w_start) begin
        r_run <= {{(PERF_W-1){1'b0}}, 1'b1};
      end else if (busy && (r_run != {PERF_W{1'b1}})) begin
        r_run <= r_run + 1'b1;
      end
      if (ack) begin
        r_perf_cycles <= r_run;
        r_perf_jobs   <= r_perf_jobs + 1'b1;
      end
    end
  end

  assign perf_cycles = r_perf_cycles;
  assign perf_jobs   = r_perf_jobs;
`endif

endmodule

// File: tb/tb_nn_layer_sequencer.sv
// Scoreboard bench: two sequencers (RD_LAT=1 and RD_LAT=3) driven by the same stimulus.
module tb_nn_layer_sequencer;
  import nn_seq_pkg::*;

  localparam int AW = 4;
  localparam int W  = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        abort;
  logic [AW:0] n_inputs;

  wire [1:0]    rd_en, mac_clr, mac_en, mac_last, out_wr, ack, busy;
  wire [AW-1:0] rd_addr0, rd_addr1;
  state_t       dbg0, dbg1;

  int lat [2] = '{1, 3};
  int cyc     = 0;
  int checks  = 0;
  int fails   = 0;
  logic [W-1:0] exp_q0[$];
  logic [W-1:0] exp_q1[$];
  string knames [6] = '{"mac_clr", "rd", "mac_en", "out_wr", "ack", "busy"};

  nn_layer_sequencer #(.AW(AW), .RD_LAT(1)) u_dut0 (
    .clk(clk), .rst(rst), .req(req), .abort(abort), .n_inputs(n_inputs),
    .rd_en(rd_en[0]), .rd_addr(rd_addr0), .mac_clr(mac_clr[0]), .mac_en(mac_en[0]),
    .mac_last(mac_last[0]), .out_wr(out_wr[0]), .ack(ack[0]), .busy(busy[0]),
    .o_dbg_state(dbg0)
  );

  nn_layer_sequencer #(.AW(AW), .RD_LAT(3)) u_dut1 (
    .clk(clk), .rst(rst), .req(req), .abort(abort), .n_inputs(n_inputs),
    .rd_en(rd_en[1]), .rd_addr(rd_addr1), .mac_clr(mac_clr[1]), .mac_en(mac_en[1]),
    .mac_last(mac_last[1]), .out_wr(out_wr[1]), .ack(ack[1]), .busy(busy[1]),
    .o_dbg_state(dbg1)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard helpers ----------------
  function automatic logic [W-1:0] ev(int c, int k, int v);
    return W'((c << 12) | (k << 8) | (v & 255));
  endfunction

  function automatic int qsize(int d);
    return (d == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  function automatic logic [W-1:0] qpop(int d);
    return (d == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
  endfunction

  function automatic logic [W-1:0] qpeek(int d);
    return (d == 0) ? exp_q0[0] : exp_q1[0];
  endfunction

  task automatic push_ev(int d, int c, int k, int v);
    if (d == 0) exp_q0.push_back(ev(c, k, v));
    else        exp_q1.push_back(ev(c, k, v));
  endtask

  function automatic int clamp_n(int n);
    return (n > 16) ? 16 : n;
  endfunction

  function automatic int end_rel(int d, int n);
    return (clamp_n(n) == 0) ? 3 : clamp_n(n) + 3 + lat[d];
  endfunction

  // Expected events of one job; cut>0 truncates after that relative cycle.
  task automatic push_job(int d, int e, int n, int cut);
    int ne, l, last_rel, wr_rel;
    ne       = clamp_n(n);
    l        = lat[d];
    last_rel = end_rel(d, n);
    wr_rel   = (ne == 0) ? 2 : ne + 2 + l;
    for (int c = 1; c <= last_rel; c++) begin
      if (cut > 0 && c > cut) break;
      if (c == 1) push_ev(d, e + c - 1, 0, 0);
      if (ne > 0 && c >= 2 && c <= ne + 1) push_ev(d, e + c - 1, 1, c - 2);
      if (ne > 0 && c >= 2 + l && c <= ne + 1 + l)
        push_ev(d, e + c - 1, 2, (c == ne + 1 + l) ? 1 : 0);
      if (c == wr_rel) push_ev(d, e + c - 1, 3, 0);
      if (c == last_rel) push_ev(d, e + c - 1, 4, 0);
      push_ev(d, e + c - 1, 5, 0);
    end
  endtask

  task automatic do_check(int d, int k, int v);
    logic [W-1:0] got, expv;
    got = ev(cyc, k, v);
    checks++;
    if (qsize(d) == 0) begin
      fails++;
      $display("FAIL dut%0d %s: got at cycle %0d data %0d, required no event", d, knames[k], cyc, v);
    end else begin
      expv = qpop(d);
      if (expv !== got)
        begin
          fails++;
          $display("FAIL dut%0d %s: got cycle %0d data %0d, required %s cycle %0d data %0d",
                   d, knames[k], cyc, v, knames[int'(expv[11:8]) % 6], int'(expv[W-1:12]),
                   int'(expv[7:0]));
        end
    end
  endtask

  task automatic drop_missed(int d);
    logic [W-1:0] e;
    bit done;
    done = 0;
    while (!done) begin
      if (qsize(d) == 0) begin
        done = 1;
      end else begin
        e = qpeek(d);
        if (int'(e[W-1:12]) < cyc) begin
          e = qpop(d);
          checks++;
          fails++;
          $display("FAIL dut%0d %s missed: got nothing, required cycle %0d data %0d",
                   d, knames[int'(e[11:8]) % 6], int'(e[W-1:12]), int'(e[7:0]));
        end else begin
          done = 1;
        end
      end
    end
  endtask

  task automatic mon_dut(int d, int addr);
    drop_missed(d);
    if (mac_clr[d])  do_check(d, 0, 0);
    if (rd_en[d])    do_check(d, 1, addr);
    if (mac_en[d])   do_check(d, 2, int'(mac_last[d]));
    if (out_wr[d])   do_check(d, 3, 0);
    if (ack[d])      do_check(d, 4, 0);
    if (busy[d])     do_check(d, 5, 0);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    mon_dut(0, int'(rd_addr0));
    mon_dut(1, int'(rd_addr1));
  end

  task automatic chk(string name, int act, int expv);
    checks++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", name, act, expv);
    end
  endtask

  task automatic chk_all_zero(string tag);
    chk({tag, " rd_en"},    int'(rd_en),    0);
    chk({tag, " rd_addr0"}, int'(rd_addr0), 0);
    chk({tag, " rd_addr1"}, int'(rd_addr1), 0);
    chk({tag, " mac_clr"},  int'(mac_clr),  0);
    chk({tag, " mac_en"},   int'(mac_en),   0);
    chk({tag, " mac_last"}, int'(mac_last), 0);
    chk({tag, " out_wr"},   int'(out_wr),   0);
    chk({tag, " ack"},      int'(ack),      0);
    chk({tag, " busy"},     int'(busy),     0);
    chk({tag, " state0"},   int'(dbg0),     int'(ST_IDLE));
    chk({tag, " state1"},   int'(dbg1),     int'(ST_IDLE));
  endtask

  // ---------------- driver ----------------
  task automatic wait_rel(int e, int r);
    while (cyc - e + 1 < r) @(negedge clk);
  endtask

  // mode: 0 = run to completion, 1 = abort during cycle cut, 2 = reset during cycle cut
  task automatic run_job(int n, int cut, int mode);
    int e;
    @(negedge clk);
    n_inputs = (AW+1)'(n);
    req      = 1'b1;
    e        = cyc + 1;
    push_job(0, e, n, cut);
    push_job(1, e, n, cut);
    @(negedge clk);
    req = 1'b0;
    if (mode == 1) begin
      wait_rel(e, cut);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
    end else if (mode == 2) begin
      wait_rel(e, cut);
      #2 rst = 1'b0;
      #1 chk_all_zero("async reset");
      @(negedge clk);
      rst = 1'b1;
    end
    wait_rel(e, end_rel(1, n) + 3);
  endtask

  task automatic run_back_to_back(int n);
    int e;
    @(negedge clk);
    n_inputs = (AW+1)'(n);
    req      = 1'b1;
    e        = cyc + 1;
    for (int d = 0; d < 2; d++) begin
      push_job(d, e, n, 0);
      push_job(d, e + end_rel(d, n), n, 0);
    end
    wait_rel(e, end_rel(1, n) + 1);
    req = 1'b0;
    wait_rel(e, 2 * end_rel(1, n) + 3);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst      = 1'b0;
    req      = 1'b0;
    abort    = 1'b0;
    n_inputs = '0;
    #3 chk_all_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    run_job(4, 0, 0);      // nominal vector
    run_job(1, 0, 0);      // single element: mac_en and mac_last coincide
    run_job(0, 0, 0);      // empty vector: no reads
    run_job(4, 4, 1);      // abort while rd_addr=2
    run_job(2, 0, 0);      // restarts from address 0
    run_job(20, 0, 0);     // clamps to 16 reads
    run_back_to_back(2);   // req held across two jobs
    run_job(2, 6, 1);      // abort in DONE (lat 1) / last DRAIN cycle (lat 3)
    run_job(4, 6, 2);      // async reset in DRAIN
    run_job(3, 0, 0);      // clean job after reset

    repeat (4) @(negedge clk);
    while (exp_q0.size() > 0 || exp_q1.size() > 0) begin
      for (int d = 0; d < 2; d++) begin
        if (qsize(d) > 0) begin
          logic [W-1:0] e;
          e = qpop(d);
          checks++;
          fails++;
          $display("FAIL dut%0d %s never seen: got nothing, required cycle %0d data %0d",
                   d, knames[int'(e[11:8]) % 6], int'(e[W-1:12]), int'(e[7:0]));
        end
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
